// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS timer control stage.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Saturate one loaded digit so the count always holds valid BCD.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/mmss_timer_ctrl_if.sv
// Control/status bundle between the timer control stage and its user.
interface mmss_timer_ctrl_if;
  logic       mode;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       stop;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       expired;

  // Master issues commands and reads back the count and status.
  modport master (
    output mode, load, load_min, load_sec, start, stop,
    input  min_bcd, sec_bcd, running, done, expired
  );

  // Slave is the timer control stage itself.
  modport slave (
    input  mode, load, load_min, load_sec, start, stop,
    output min_bcd, sec_bcd, running, done, expired
  );
endinterface

// File: rtl/bcd_digit_step.sv
// One BCD digit of the ripple counter: step up or down with wrap and carry/borrow out.
module bcd_digit_step
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [3:0] limit,
  input  logic       dir,
  input  logic       step_in,
  output logic [3:0] next_digit,
  output logic       step_out
);

  // Apply a single step when the lower digit (or the tick) asks for one.
  always_comb begin
    next_digit = digit;
    step_out   = 1'b0;
    if (step_in) begin
      if (dir == MODE_DOWN) begin
        if (digit == 4'd0) begin
          next_digit = limit;
          step_out   = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end else begin
        if (digit >= limit) begin
          next_digit = 4'd0;
          step_out   = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mmss_timer_ctrl.sv
// MM:SS countdown/stopwatch control: FSM, prescaler and BCD count register.
module mmss_timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  mmss_timer_ctrl_if.slave  bus
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   count_q, count_d;   // {min tens, min units, sec tens, sec units}
  logic          mode_q, mode_d;
  logic          done_q, done_d;

  logic [15:0]   stepped;
  logic [4:0]    carry;
  logic [15:0]   load_count;
  logic          tick;
  logic          start_ok;
  logic          step_terminal;

  // Ripple chain: sec units, sec tens, min units, min tens; the tick always steps digit 0.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIM = (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;
      bcd_digit_step u_digit (
        .digit      (count_q[gi*4 +: 4]),
        .limit      (LIM),
        .dir        (mode_q),
        .step_in    (carry[gi]),
        .next_digit (stepped[gi*4 +: 4]),
        .step_out   (carry[gi+1])
      );
    end
  endgenerate

  assign load_count = {clamp_digit(bus.load_min[7:4], DIGIT_MAX),
                       clamp_digit(bus.load_min[3:0], DIGIT_MAX),
                       clamp_digit(bus.load_sec[7:4], SEC_TENS_MAX),
                       clamp_digit(bus.load_sec[3:0], DIGIT_MAX)};

  assign tick = (presc_q == PRESC_LAST);

  // A countdown from 00:00 would expire immediately, so such a start is refused.
  assign start_ok = bus.start && !bus.stop &&
                    !((bus.mode == MODE_DOWN) && (count_q == 16'h0000));

  // Up counting ends at 59:59; carry out of the top digit (loaded >59 min) also ends it.
  assign step_terminal = (mode_q == MODE_DOWN) ? (stepped == 16'h0000)
                                               : ((stepped == 16'h5959) || carry[4]);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= '0;
      mode_q  <= MODE_UP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load > stop > start; terminal step beats stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, PAUSE: begin
        if (bus.load)     state_d = IDLE;
        else if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (tick && step_terminal) state_d = DONE;
        else if (bus.stop)         state_d = PAUSE;
      end
      DONE: begin
        if (bus.load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic: count, prescaler, latched mode and done pulse.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    done_d  = (state_d == DONE) && (state_q != DONE);
    if (state_q == RUN) begin
      if (tick) begin
        presc_d = '0;
        // Hold rather than wrap when the top digit overflows.
        count_d = ((mode_q == MODE_UP) && carry[4]) ? count_q : stepped;
      end else if (!bus.stop) begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      if (bus.load) begin
        count_d = load_count;
        presc_d = '0;
      end else if ((state_q != DONE) && start_ok) begin
        mode_d = bus.mode;
      end
    end
  end

  assign bus.min_bcd = count_q[15:8];
  assign bus.sec_bcd = count_q[7:0];
  assign bus.running = (state_q == RUN);
  assign bus.expired = (state_q == DONE);
  assign bus.done    = done_q;

endmodule
